// File: rtl/modport_slave_if.sv
//==============================================================================
// modport_slave_if : APB-style bus bundle with master and slave views
// Rev 1.0
//==============================================================================
`default_nettype none

interface modport_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/modport_slave.sv
//==============================================================================
// modport_slave : APB slave over a byte-strobed word memory, registered response
// Rev 1.0
//==============================================================================
`default_nettype none

module modport_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  modport_slave_if.slave  apb
);

  localparam int c_STRB_W    = DATA_WIDTH / 8;
  localparam int c_OFFS_BITS = (c_STRB_W > 1) ? $clog2(c_STRB_W) : 0;
  localparam int c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_OFFS_MASK = ADDR_WIDTH'((1 << c_OFFS_BITS) - 1);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH     = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0]            c_WAIT      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_capture;
  logic                  w_complete;
  logic                  w_abort;
  logic                  w_tick;

  logic [c_IDX_W-1:0]    r_idx;
  logic                  r_valid;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_STRB_W-1:0]   r_strb;
  logic [3:0]            r_wait;

  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic [c_IDX_W-1:0]    w_in_idx;
  logic                  w_in_valid;
  logic [c_IDX_W-1:0]    w_rsp_idx;
  logic                  w_rsp_valid;
  logic                  w_rsp_write;
  logic                  w_rsp_set;
  logic                  w_mem_we;

  assign w_idx_full = apb.PADDR >> c_OFFS_BITS;
  assign w_in_idx   = c_IDX_W'(w_idx_full);
  assign w_in_valid = (w_idx_full < c_DEPTH) && ((apb.PADDR & c_OFFS_MASK) == '0);

  // SETUP marks the first access cycle after capture; ACCESS covers any later wait cycles.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          w_capture   = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP, ACCESS: begin
        if (!apb.PSEL) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_pready && apb.PENABLE) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tick      = !r_pready;
          w_state_nxt = ACCESS;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With no wait states the response is formed straight from the bus at capture.
  always_comb begin
    w_rsp_idx   = r_idx;
    w_rsp_valid = r_valid;
    w_rsp_write = r_write;
    if (w_capture) begin
      w_rsp_idx   = w_in_idx;
      w_rsp_valid = w_in_valid;
      w_rsp_write = apb.PWRITE;
    end
  end

  assign w_rsp_set = (w_capture && (c_WAIT == 4'd0)) || (w_tick && (r_wait == 4'd1));
  assign w_mem_we  = w_complete && r_write && r_valid;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_wait  <= 4'd0;
    end else begin
      if (w_capture) begin
        r_idx   <= w_in_idx;
        r_valid <= w_in_valid;
        r_write <= apb.PWRITE;
        r_wdata <= apb.PWDATA;
        r_strb  <= apb.PSTRB;
        r_wait  <= c_WAIT;
      end else if (w_complete || w_abort) begin
        r_wait  <= 4'd0;
      end else if (w_tick && (r_wait != 4'd0)) begin
        r_wait  <= r_wait - 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      if (w_complete || w_abort) begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end else if (w_rsp_set) begin
        r_pready  <= 1'b1;
        r_pslverr <= !w_rsp_valid;
        if (!w_rsp_write) begin
          r_prdata <= w_rsp_valid ? r_mem[w_rsp_idx] : '0;
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;

endmodule

`default_nettype wire

// File: tb/tb_modport_slave.sv
//==============================================================================
// tb_modport_slave : scoreboard bench for modport_slave, zero and three wait states
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_modport_slave;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  always #5 PCLK = ~PCLK;

  modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus0.slave)
  );

  modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus3.slave)
  );

  logic        psel, penable, pwrite, sel3;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  assign bus0.PSEL    = psel & ~sel3;
  assign bus3.PSEL    = psel & sel3;
  assign bus0.PENABLE = penable;
  assign bus3.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus3.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus3.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PWDATA  = pwdata;
  assign bus0.PSTRB   = pstrb;
  assign bus3.PSTRB   = pstrb;
  assign pready  = sel3 ? bus3.PREADY  : bus0.PREADY;
  assign pslverr = sel3 ? bus3.PSLVERR : bus0.PSLVERR;
  assign prdata  = sel3 ? bus3.PRDATA  : bus0.PRDATA;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [2][256];
  logic [31:0] m_last [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 32'h0;
      for (int i = 0; i < 256; i++) m_mem[d][i] = 32'h0;
    end
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge PCLK); #1;
  endtask

  // Called just after a rising edge; returns just after the completing edge with PSEL still high.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit scramble);
    int   d;
    int   idx;
    int   n;
    logic ok;
    exp_t e;
    d   = sel3 ? 1 : 0;
    ok  = (addr[31:2] < 30'd256) && (addr[1:0] == 2'b00);
    idx = int'(addr[9:2]);
    e.err = !ok;
    e.cyc = sel3 ? 4 : 1;
    if (wr) begin
      if (ok) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_mem[d][idx][b*8 +: 8] = data[b*8 +: 8];
      end
      e.rdata = m_last[d];
    end else begin
      e.rdata   = ok ? m_mem[d][idx] : 32'h0;
      m_last[d] = e.rdata;
    end
    sb_q.push_back(e);

    check_value("pready_setup", 32'(pready), 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge PCLK); #1;
    penable = 1'b1;
    n = 1;
    while (!pready && n < 20) begin
      if (scramble) begin
        paddr = addr ^ 32'h4; pwdata = ~data; pstrb = ~strb; pwrite = ~wr;
      end
      @(posedge PCLK); #1;
      n++;
    end
    e = sb_q.pop_front();
    if (!pready) begin
      check_value("timeout", 32'(pready), 32'h1);
      bus_idle();
      return;
    end
    check_value("cycles",  32'(n),       32'(e.cyc));
    check_value("prdata",  prdata,       e.rdata);
    check_value("pslverr", 32'(pslverr), 32'(e.err));
    @(posedge PCLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    psel = 0; penable = 0; pwrite = 0; sel3 = 0;
    paddr = 0; pwdata = 0; pstrb = 0;
    model_clear();
    repeat (3) @(posedge PCLK);
    #1;
    check_value("rst_pready",  32'(pready),  32'h0);
    check_value("rst_pslverr", 32'(pslverr), 32'h0);
    check_value("rst_prdata",  prdata,       32'h0);
    PRESETn = 1'b0;
    bus_idle();

    // basic write/read and strobed merge, back-to-back
    apb_xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    bus_idle();
    apb_xfer(0, 32'h10, 32'h0, 4'h0, 0);
    apb_xfer(1, 32'h20, 32'h11223344, 4'hF, 0);
    apb_xfer(1, 32'h20, 32'hAABBCCDD, 4'h5, 0);
    apb_xfer(0, 32'h20, 32'h0, 4'hF, 0);
    apb_xfer(1, 32'h10, 32'h01020304, 4'h0, 0);
    apb_xfer(0, 32'h10, 32'h0, 4'h0, 0);

    // out-of-range and misaligned accesses
    apb_xfer(0, 32'h400, 32'h0, 4'h0, 0);
    apb_xfer(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    apb_xfer(0, 32'h13, 32'h0, 4'h0, 0);
    apb_xfer(1, 32'h13, 32'h12345678, 4'hF, 0);
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0);
    apb_xfer(0, 32'h10, 32'h0, 4'h0, 0);
    bus_idle();

    // three wait states, inputs disturbed during access
    sel3 = 1'b1;
    apb_xfer(1, 32'h0, 32'hCAFEF00D, 4'hF, 1);
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 1);
    apb_xfer(0, 32'h4, 32'h0, 4'h0, 0);
    bus_idle();

    // abort by dropping PSEL before PREADY
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0; pwdata = 32'h77; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1;
    @(posedge PCLK); #1;
    check_value("abort_wait", 32'(pready), 32'h0);
    psel = 0; penable = 0;
    @(posedge PCLK); #1;
    check_value("abort_idle", 32'(pready), 32'h0);
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0);
    bus_idle();
    sel3 = 1'b0;

    // PENABLE without a setup phase is ignored, then back-to-back writes
    psel = 1; penable = 1; pwrite = 1; paddr = 32'hC; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(posedge PCLK); #1;
      check_value("no_setup", 32'(pready), 32'h0);
    end
    apb_xfer(1, 32'h4, 32'h44444444, 4'hF, 0);
    apb_xfer(1, 32'h8, 32'h88888888, 4'hF, 0);
    apb_xfer(0, 32'hC, 32'h0, 4'h0, 0);
    apb_xfer(0, 32'h4, 32'h0, 4'h0, 0);
    apb_xfer(0, 32'h10, 32'h0, 4'h0, 0);
    bus_idle();

    // asynchronous reset in the middle of a write
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h8; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1;
    check_value("rst_mid_pready", 32'(pready), 32'h1);
    #3;
    PRESETn = 1'b1;
    #1;
    check_value("arst_pready",  32'(pready),  32'h0);
    check_value("arst_pslverr", 32'(pslverr), 32'h0);
    check_value("arst_prdata",  prdata,       32'h0);
    psel = 0; penable = 0;
    model_clear();
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    bus_idle();
    apb_xfer(0, 32'h8, 32'h0, 4'h0, 0);
    apb_xfer(0, 32'h20, 32'h0, 4'h0, 0);
    bus_idle();
    sel3 = 1'b1;
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0);
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 32, PADDR width; DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8); MEM_DEPTH, 256, number of DATA_WIDTH-bit words; WAIT_STATES, 0, extra access cycles before PREADY (0..15).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- PCLK, input, 1, clock; all state changes on rising edge.
- PRESETn, input, 1, asynchronous reset, active-high (name kept from codebase; high = reset).
- PSEL, input, 1, slave select.
- PENABLE, input, 1, access phase marker.
- PWRITE, input, 1, 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH, byte address.
- PWDATA, input, DATA_WIDTH, write data.
- PSTRB, input, DATA_WIDTH/8, write byte strobes.
- PRDATA, output, DATA_WIDTH, read data.
- PREADY, output, 1, transfer complete.
- PSLVERR, output, 1, transfer error.
REQ-004 All outputs SHALL be registered (driven from flops updated on PCLK rising edge).

Function
REQ-005 FSM states IDLE, SETUP, ACCESS; IDLE->SETUP when PSEL=1,PENABLE=0; SETUP->ACCESS unconditionally next edge; ACCESS->IDLE when PREADY=1 and PENABLE=1, or PSEL=0.
REQ-006 Word index = PADDR>>log2(DATA_WIDTH/8); address valid iff index < MEM_DEPTH and low byte-offset bits are zero.
REQ-007 Address, PWRITE, PWDATA, PSTRB SHALL be captured at the edge ending the setup cycle.
REQ-008 PREADY SHALL be 1 in the access cycle after WAIT_STATES waited access cycles (WAIT_STATES=0 -> PREADY high in first access cycle, i.e. 2-cycle transfer); PREADY=0 in all other cycles.
REQ-009 PSLVERR SHALL equal 1 only while PREADY=1 for an invalid address; otherwise 0.
REQ-010 Write: at the completing edge (PSEL=PENABLE=PREADY=1), valid address, byte i of word updated iff PSTRB[i]=1; PSTRB=0 -> no change.
REQ-011 Write with invalid address: memory unchanged, PSLVERR=1.
REQ-012 Read: PRDATA = addressed word while PREADY=1; PSTRB ignored; invalid address -> PRDATA=0, PSLVERR=1.
REQ-013 PRDATA SHALL hold its last value outside read completion cycles; memory never modified by reads.
REQ-014 PENABLE=1 while in IDLE (no setup phase) SHALL be ignored: no access, PREADY stays 0.
REQ-015 PSEL dropped during ACCESS before PREADY: transfer aborted, no memory update, return to IDLE.
REQ-016 Back-to-back transfers: new setup cycle immediately after completion SHALL be accepted without idle cycle.
REQ-017 Changes on captured inputs during ACCESS SHALL NOT affect the current transfer.

Reset
REQ-018 PRESETn=1 SHALL immediately (asynchronously) force state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter 0.
REQ-019 Reset SHALL clear all memory words to 0.
REQ-020 Reset during ACCESS SHALL abort the transfer with no memory update; operation resumes on first edge after PRESETn=0.

Verification
REQ-021 Write 0xDEADBEEF to 0x10, PSTRB=0xF, then read 0x10 -> PRDATA=0xDEADBEEF, PREADY high in 2nd cycle, PSLVERR=0.
REQ-022 Write 0x11223344 to 0x20 (PSTRB=0xF), then 0xAABBCCDD with PSTRB=0x5 -> read 0x11BB33DD.
REQ-023 Read and write to 0x400 (index 256) and misaligned 0x13 -> PSLVERR=1 with PREADY, PRDATA=0, memory unchanged.
REQ-024 WAIT_STATES=3: transfer to 0x0 -> PREADY low 3 access cycles, high on 4th; data correct.
REQ-025 Assert PRESETn=1 mid-access of write 0x55 to 0x8 -> outputs 0 asynchronously; later read of 0x8 -> 0x00000000.
REQ-026 PENABLE=1 without prior setup, then back-to-back writes 0x4/0x8 -> first ignored, both writes complete in 2 cycles each.
